// File: rtl/surf_cout_parallel_tx.sv
//==============================================================================
// Module   : surf_cout_parallel_tx
// Brief    : Serializes 32-bit command words into LSB-first 4-bit nibbles,
//            8 beats per word, with training / run framing and a 1-entry buffer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module surf_cout_parallel_tx #(
   parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
   parameter logic [31:0] IDLE_WORD      = 32'h00000000
) (
   input  logic        aclk_i,
   input  logic        aclk_rstn_i,
   input  logic        cout_valid_i,
   input  logic        train_i,
   input  logic [31:0] dat_i,
   input  logic        dat_valid_i,
   output logic        dat_ready_o,
   output logic [3:0]  cout_o,
   output logic        cout_valid_o,
   output logic        frame_o,
   output logic        running_o
);

   localparam logic [0:0] c_st_train = 1'b0;
   localparam logic [0:0] c_st_run   = 1'b1;

   logic [0:0]  r_state;
   logic [2:0]  r_beat;
   logic [31:0] r_cur;
   logic [31:0] r_buf;
   logic        r_buf_full;
   logic [3:0]  r_cout;
   logic        r_cout_valid;
   logic        r_frame;

   logic        w_boundary;
   logic        w_push;
   logic        w_consume;
   logic [0:0]  w_next_state;
   logic [31:0] w_next_word;

   // State and word changes are confined to the last beat so a word never tears.
   assign w_boundary   = cout_valid_i && (r_beat == 3'd7);
   assign w_push       = dat_valid_i && !r_buf_full;
   assign w_consume    = w_boundary && !train_i && r_buf_full;
   assign w_next_state = train_i ? c_st_train : c_st_run;

   always_comb begin
      w_next_word = IDLE_WORD;
      if (train_i)
         w_next_word = TRAIN_SEQUENCE;
      else if (r_buf_full)
         w_next_word = r_buf;
   end

   always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
      if (!aclk_rstn_i) begin
         r_state      <= c_st_train;
         r_beat       <= 3'd0;
         r_cur        <= TRAIN_SEQUENCE;
         r_buf        <= 32'd0;
         r_buf_full   <= 1'b0;
         r_cout       <= 4'd0;
         r_cout_valid <= 1'b0;
         r_frame      <= 1'b0;
      end else begin
         r_cout_valid <= cout_valid_i;
         r_frame      <= cout_valid_i && (r_beat == 3'd0);
         if (cout_valid_i) begin
            r_cout <= r_cur[{r_beat, 2'b00} +: 4];
            r_beat <= r_beat + 3'd1;
         end
         if (w_boundary) begin
            r_state <= w_next_state;
            r_cur   <= w_next_word;
         end
         // Push and consume are mutually exclusive: push needs an empty buffer.
         if (w_push) begin
            r_buf      <= dat_i;
            r_buf_full <= 1'b1;
         end else if (w_consume) begin
            r_buf_full <= 1'b0;
         end
      end
   end

   assign dat_ready_o  = !r_buf_full;
   assign cout_o       = r_cout;
   assign cout_valid_o = r_cout_valid;
   assign frame_o      = r_frame;
   assign running_o    = (r_state == c_st_run);

endmodule

`default_nettype wire

// File: tb/tb_surf_cout_parallel_tx.sv
//==============================================================================
// Module   : tb_surf_cout_parallel_tx
// Brief    : Directed self-checking bench for surf_cout_parallel_tx.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_surf_cout_parallel_tx;

   logic        aclk_i;
   logic        aclk_rstn_i;
   logic        cout_valid_i;
   logic        train_i;
   logic [31:0] dat_i;
   logic        dat_valid_i;
   logic        dat_ready_o;
   logic [3:0]  cout_o;
   logic        cout_valid_o;
   logic        frame_o;
   logic        running_o;

   int n_err;
   int n_chk;

   localparam logic [31:0] c_train = 32'hA55A6996;

   surf_cout_parallel_tx #(
      .TRAIN_SEQUENCE(32'hA55A6996),
      .IDLE_WORD     (32'h00000000)
   ) dut (
      .aclk_i      (aclk_i),
      .aclk_rstn_i (aclk_rstn_i),
      .cout_valid_i(cout_valid_i),
      .train_i     (train_i),
      .dat_i       (dat_i),
      .dat_valid_i (dat_valid_i),
      .dat_ready_o (dat_ready_o),
      .cout_o      (cout_o),
      .cout_valid_o(cout_valid_o),
      .frame_o     (frame_o),
      .running_o   (running_o)
   );

   initial aclk_i = 1'b0;
   always #5 aclk_i = ~aclk_i;

   task automatic step();
      @(posedge aclk_i);
      #1;
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int b);
      nib = w[4*b +: 4];
   endfunction

   // Emit one full word (8 enabled cycles) and check nibbles and framing.
   task automatic emit_word(input logic [31:0] w, input string tag);
      for (int b = 0; b < 8; b++) begin
         cout_valid_i = 1'b1;
         step();
         n_chk++;
         if (cout_o !== nib(w, b) || frame_o !== (b == 0) || cout_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s beat%0d: cout=%h frame=%b vld=%b, need cout=%h frame=%b vld=1",
                     tag, b, cout_o, frame_o, cout_valid_o, nib(w, b), (b == 0));
         end
      end
   endtask

   task automatic test_reset();
      aclk_rstn_i = 1'b0; cout_valid_i = 1'b1; train_i = 1'b1;
      dat_i = 32'd0; dat_valid_i = 1'b0;
      step(); step();
      n_chk++;
      if ({cout_o, cout_valid_o, frame_o, running_o, dat_ready_o} !== 8'b0000_0001) begin
         n_err++;
         $display("FAIL reset: cout=%h vld=%b frame=%b run=%b rdy=%b, need 0 0 0 0 1",
                  cout_o, cout_valid_o, frame_o, running_o, dat_ready_o);
      end
      aclk_rstn_i = 1'b1;
   endtask

   task automatic test_training();
      train_i = 1'b1;
      emit_word(c_train, "train0");
      emit_word(c_train, "train1");
      n_chk++;
      if (dat_ready_o !== 1'b1 || running_o !== 1'b0) begin
         n_err++;
         $display("FAIL train_flags: rdy=%b run=%b, need 1 0", dat_ready_o, running_o);
      end
   endtask

   task automatic test_release();
      for (int b = 0; b < 8; b++) begin
         if (b == 3) train_i = 1'b0;
         cout_valid_i = 1'b1;
         step();
         n_chk++;
         if (cout_o !== nib(c_train, b) || running_o !== (b == 7)) begin
            n_err++;
            $display("FAIL release beat%0d: cout=%h run=%b, need cout=%h run=%b",
                     b, cout_o, running_o, nib(c_train, b), (b == 7));
         end
      end
      emit_word(32'h0, "idle_after_release");
      n_chk++;
      if (running_o !== 1'b1) begin
         n_err++;
         $display("FAIL running: got %b need 1", running_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      logic        rdy_exp;
      dat_valid_i = 1'b1;
      dat_i       = 32'h12345678;
      for (int i = 0; i < 24; i++) begin
         if (i == 1) dat_i = 32'hDEADBEEF;
         if (i == 9) dat_valid_i = 1'b0;
         cout_valid_i = 1'b1;
         step();
         w = (i < 8) ? 32'h0 : (i < 16) ? 32'h12345678 : 32'hDEADBEEF;
         rdy_exp = !((i <= 6) || (i >= 8 && i <= 14));
         n_chk++;
         if (cout_o !== nib(w, i % 8) || frame_o !== ((i % 8) == 0) || dat_ready_o !== rdy_exp) begin
            n_err++;
            $display("FAIL b2b cyc%0d: cout=%h frame=%b rdy=%b, need cout=%h frame=%b rdy=%b",
                     i, cout_o, frame_o, dat_ready_o, nib(w, i % 8), ((i % 8) == 0), rdy_exp);
         end
      end
   endtask

   task automatic test_irregular();
      logic        en;
      logic [31:0] w;
      logic [3:0]  held;
      int          k;
      cout_valid_i = 1'b0;
      dat_valid_i  = 1'b1;
      dat_i        = 32'hCAFE0001;
      step();
      dat_valid_i = 1'b0;
      n_chk++;
      if (dat_ready_o !== 1'b0 || cout_valid_o !== 1'b0 || frame_o !== 1'b0) begin
         n_err++;
         $display("FAIL irr_push: rdy=%b vld=%b frame=%b, need 0 0 0",
                  dat_ready_o, cout_valid_o, frame_o);
      end
      held = cout_o;
      k    = 0;
      for (int c = 0; c < 24; c++) begin
         en = ((c % 3) != 2);
         cout_valid_i = en;
         step();
         w = (k < 8) ? 32'h0 : 32'hCAFE0001;
         n_chk++;
         if (en) begin
            if (cout_valid_o !== 1'b1 || cout_o !== nib(w, k % 8) || frame_o !== ((k % 8) == 0)) begin
               n_err++;
               $display("FAIL irr cyc%0d: vld=%b cout=%h frame=%b, need 1 %h %b",
                        c, cout_valid_o, cout_o, frame_o, nib(w, k % 8), ((k % 8) == 0));
            end
            held = nib(w, k % 8);
            k++;
         end else if (cout_valid_o !== 1'b0 || cout_o !== held || frame_o !== 1'b0) begin
            n_err++;
            $display("FAIL irr_hold cyc%0d: vld=%b cout=%h frame=%b, need 0 %h 0",
                     c, cout_valid_o, cout_o, frame_o, held);
         end
      end
   endtask

   task automatic test_retrain();
      cout_valid_i = 1'b1;
      step(); step();
      train_i     = 1'b1;
      dat_valid_i = 1'b1;
      dat_i       = 32'h0000000F;
      for (int b = 2; b < 8; b++) begin
         step();
         dat_valid_i = 1'b0;
         n_chk++;
         if (cout_o !== 4'h0 || running_o !== (b != 7)) begin
            n_err++;
            $display("FAIL retrain beat%0d: cout=%h run=%b, need 0 %b", b, cout_o, running_o, (b != 7));
         end
      end
      emit_word(c_train, "retrain_train");
      n_chk++;
      if (dat_ready_o !== 1'b0 || running_o !== 1'b0) begin
         n_err++;
         $display("FAIL retrain_buf: rdy=%b run=%b, need 0 0", dat_ready_o, running_o);
      end
      train_i = 1'b0;
      emit_word(c_train, "retrain_last_train");
      emit_word(32'h0000000F, "retained_word");
      n_chk++;
      if (dat_ready_o !== 1'b1 || running_o !== 1'b1) begin
         n_err++;
         $display("FAIL retained_flags: rdy=%b run=%b, need 1 1", dat_ready_o, running_o);
      end
   endtask

   task automatic test_async_reset();
      cout_valid_i = 1'b0;
      dat_valid_i  = 1'b1;
      dat_i        = 32'h89ABCDEF;
      step();
      dat_valid_i = 1'b0;
      emit_word(32'h0, "pre_reset_idle");
      dat_valid_i = 1'b1;
      dat_i       = 32'h11111111;
      for (int b = 0; b < 5; b++) begin
         cout_valid_i = 1'b1;
         step();
         dat_valid_i = 1'b0;
         n_chk++;
         if (cout_o !== nib(32'h89ABCDEF, b)) begin
            n_err++;
            $display("FAIL pre_reset beat%0d: cout=%h need %h", b, cout_o, nib(32'h89ABCDEF, b));
         end
      end
      #2 aclk_rstn_i = 1'b0;
      #1;
      n_chk++;
      if ({cout_o, cout_valid_o, frame_o, running_o, dat_ready_o} !== 8'b0000_0001) begin
         n_err++;
         $display("FAIL async_reset: cout=%h vld=%b frame=%b run=%b rdy=%b, need 0 0 0 0 1",
                  cout_o, cout_valid_o, frame_o, running_o, dat_ready_o);
      end
      step();
      aclk_rstn_i = 1'b1;
      emit_word(c_train, "post_reset_train");
      emit_word(32'h0, "post_reset_idle");
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      test_reset();
      test_training();
      test_release();
      test_back_to_back();
      test_irregular();
      test_retrain();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
